// File: rtl/core_pkg.sv
// Shared RV64I core definitions: widths, reset defaults, base opcodes and the
// fetch-stage state encoding.
`timescale 1ns/1ps
package core_pkg;

  localparam int unsigned XLEN          = 64;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DFLT = 64'h0000_0000_0000_0000;

  // Major opcodes (instr[6:0]) used by decode and the immediate generator
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_FETCH,
    FS_DRAIN,
    FS_DELIVER,
    FS_FAULT
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, runs the req/ack handshake to instruction memory
// and hands one instruction at a time to decode.
`timescale 1ns/1ps
module instruction_fetch_unit #(
  parameter int unsigned      XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = core_pkg::RESET_PC_DFLT[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            misaligned_fault
);
  import core_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_hold_q, addr_hold_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            fault_q, fault_d;
  logic            redir_bad;

  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // DRAIN keeps presenting the abandoned address until memory answers it
  assign imem_req         = (state_q == FS_FETCH) || (state_q == FS_DRAIN);
  assign imem_addr        = (state_q == FS_DRAIN) ? addr_hold_q : pc_q;
  assign instr_valid      = (state_q == FS_DELIVER);
  assign instr            = instr_q;
  assign instr_pc         = instr_pc_q;
  assign misaligned_fault = fault_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_hold_d = addr_hold_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    fault_d     = fault_q;

    unique case (state_q)
      FS_IDLE: state_d = FS_FETCH;

      FS_FETCH: begin
        if (redir_bad) begin
          state_d = FS_FAULT;
          fault_d = 1'b1;
        end else if (redirect_valid) begin
          // With an ack the response is simply dropped and we refetch next cycle
          pc_d = redirect_pc;
          if (!imem_ack) begin
            addr_hold_d = pc_q;
            state_d     = FS_DRAIN;
          end
        end else if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = FS_DELIVER;
        end
      end

      FS_DRAIN: begin
        if (redir_bad) begin
          state_d = FS_FAULT;
          fault_d = 1'b1;
        end else begin
          if (redirect_valid) pc_d = redirect_pc;
          if (imem_ack) state_d = FS_FETCH;
        end
      end

      FS_DELIVER: begin
        // Redirects are only sampled on the cycle decode takes the instruction
        if (!stall) begin
          if (redir_bad) begin
            state_d = FS_FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d    = redirect_valid ? redirect_pc : (pc_q + XLEN'(4));
            state_d = FS_FETCH;
          end
        end
      end

      FS_FAULT: state_d = FS_FAULT;

      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FS_IDLE;
      pc_q        <= RESET_PC;
      addr_hold_q <= RESET_PC;
      instr_q     <= NOP_INSTR;
      instr_pc_q  <= RESET_PC;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_hold_q <= addr_hold_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      fault_q     <= fault_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by a randomized
// memory/decode environment checked against a PC-stream reference model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        misaligned_fault;

  int n_chk  = 0;
  int n_fail = 0;

  instruction_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .stall            (stall),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .misaligned_fault (misaligned_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of address
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h8) return 32'h00A0_0093;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_req"},   imem_req, 0);
    check({tag, "_addr"},  imem_addr, 64'h0);
    check({tag, "_vld"},   instr_valid, 0);
    check({tag, "_instr"}, instr, 64'h13);
    check({tag, "_pc"},    instr_pc, 64'h0);
    check({tag, "_fault"}, misaligned_fault, 0);
  endtask

  task automatic serve();
    imem_ack   = imem_req;
    imem_rdata = mem_word(imem_addr);
  endtask

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    case ($urandom_range(0, 2))
      0:       t = {32'h0, $urandom};
      1:       t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      default: t = {$urandom, $urandom};
    endcase
    return t & ~64'h3;
  endfunction

  // Random-phase model state
  logic [63:0] exp_pc, p_addr, p_pc;
  logic [31:0] p_instr;
  logic        p_req, p_ack, p_vld, p_stall, new_req, accept, honoured;
  int          lat, n_acc;

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    #1;
    check_reset("rst");
    @(negedge clk); reset = 1'b0;
    check("idle_req", imem_req, 0);
    @(negedge clk);

    // Zero-wait memory: one instruction every two cycles
    for (int k = 0; k < 3; k++) begin
      check("zw_req", imem_req, 1);
      check("zw_addr", imem_addr, 64'(4 * k));
      check("zw_vld0", instr_valid, 0);
      serve();
      @(negedge clk);
      imem_ack = 1'b0;
      check("zw_vld", instr_valid, 1);
      check("zw_pc", instr_pc, 64'(4 * k));
      check("zw_instr", instr, mem_word(64'(4 * k)));
      if (k < 2) @(negedge clk);
    end

    // Stall for three cycles; a misaligned redirect meanwhile must be ignored
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      check("stl_vld", instr_valid, 1);
      check("stl_pc", instr_pc, 64'h8);
      check("stl_instr", instr, 64'h00A0_0093);
      check("stl_req", imem_req, 0);
      redirect_valid = 1'b1; redirect_pc = 64'h302;
      @(negedge clk);
    end
    stall = 1'b0; redirect_valid = 1'b0;
    check("stl_vld_last", instr_valid, 1);
    @(negedge clk);
    check("stl_next_addr", imem_addr, 64'hC);
    check("stl_next_req", imem_req, 1);
    check("stl_nofault", misaligned_fault, 0);
    serve();
    @(negedge clk);
    imem_ack = 1'b0;
    check("acc_pc", instr_pc, 64'hC);
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("rd_addr", imem_addr, 64'h100);
    serve();
    @(negedge clk);
    imem_ack = 1'b0;
    check("rd_pc", instr_pc, 64'h100);
    check("rd_instr", instr, mem_word(64'h100));
    redirect_valid = 1'b1; redirect_pc = 64'h10;
    @(negedge clk);

    // Slow memory, redirect in the first FETCH cycle
    check("dr_addr0", imem_addr, 64'h10);
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("dr_addr1", imem_addr, 64'h10);
    check("dr_req1", imem_req, 1);
    check("dr_vld1", instr_valid, 0);
    @(negedge clk);
    check("dr_addr2", imem_addr, 64'h10);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    check("dr_vld3", instr_valid, 0);
    check("dr_new_addr", imem_addr, 64'h200);
    serve();
    @(negedge clk);
    imem_ack = 1'b0;
    check("dr_pc", instr_pc, 64'h200);
    check("dr_instr", instr, mem_word(64'h200));
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);

    // PC wrap at the top of the address space
    redirect_valid = 1'b0;
    check("wr_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    serve();
    @(negedge clk);
    imem_ack = 1'b0;
    check("wr_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    check("wr_next", imem_addr, 64'h0);
    serve();
    @(negedge clk);
    imem_ack = 1'b0;
    check("wr_vld", instr_valid, 1);

    // Misaligned redirect on accept
    redirect_valid = 1'b1; redirect_pc = 64'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int f = 0; f < 4; f++) begin
      check("mf_fault", misaligned_fault, 1);
      check("mf_req", imem_req, 0);
      check("mf_vld", instr_valid, 0);
      imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h400;
      @(negedge clk);
    end
    imem_ack = 1'b0; redirect_valid = 1'b0;

    // Reset in the middle of a DRAIN, then a late ack
    reset = 1'b1;
    #1;
    check("mf_rst_fault", misaligned_fault, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("rd2_req", imem_req, 1);
    redirect_valid = 1'b1; redirect_pc = 64'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("rd2_drain_addr", imem_addr, 64'h0);
    #2 reset = 1'b1; imem_ack = 1'b1;
    #1;
    check_reset("mid");
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    check("late_req", imem_req, 1);
    check("late_addr", imem_addr, 64'h0);
    check("late_vld", instr_valid, 0);
    @(negedge clk);
    check("late_vld2", instr_valid, 0);
    check("late_addr2", imem_addr, 64'h0);

    // Randomized environment against the PC-stream model
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    exp_pc = 64'h0; p_req = 1'b0; p_ack = 1'b0; p_vld = 1'b0; p_stall = 1'b0;
    p_addr = '0; p_pc = '0; p_instr = '0; lat = 0; n_acc = 0;
    repeat (3000) begin
      @(negedge clk);
      new_req = imem_req && (!p_req || p_ack);
      check("r_fault", misaligned_fault, 0);
      check("r_excl", imem_req && instr_valid, 0);
      if (imem_req) begin
        if (new_req) check("r_addr_new", imem_addr, exp_pc);
        else         check("r_addr_hold", imem_addr, p_addr);
      end
      if (p_vld && p_stall) begin
        check("r_stl_vld", instr_valid, 1);
        check("r_stl_pc", instr_pc, p_pc);
        check("r_stl_instr", instr, p_instr);
      end
      if (instr_valid) begin
        check("r_pc", instr_pc, exp_pc);
        check("r_instr", instr, mem_word(instr_pc));
      end

      if (imem_req) begin
        if (new_req) lat = $urandom_range(0, 3);
        else if (lat > 0) lat--;
        imem_ack   = (lat == 0);
        imem_rdata = mem_word(imem_addr);
      end else begin
        imem_ack   = ($urandom_range(0, 7) == 0);
        imem_rdata = $urandom;
      end
      stall    = instr_valid ? ($urandom_range(0, 2) == 0) : $urandom_range(0, 1) == 1;
      accept   = instr_valid && !stall;
      honoured = 1'b0;
      if (imem_req || accept) begin
        redirect_valid = ($urandom_range(0, 5) == 0);
        redirect_pc    = pick_target();
        honoured       = redirect_valid;
      end else if (instr_valid && $urandom_range(0, 3) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = {$urandom, $urandom} | 64'h2;
      end else begin
        redirect_valid = 1'b0;
      end

      if (honoured)    exp_pc = redirect_pc;
      else if (accept) exp_pc = exp_pc + 64'd4;
      if (accept) n_acc++;

      p_req   = imem_req;
      p_ack   = imem_req && imem_ack;
      p_addr  = imem_addr;
      p_vld   = instr_valid;
      p_stall = stall;
      p_pc    = instr_pc;
      p_instr = instr;
    end
    check("r_progress", n_acc > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the RV64I core. Owns the program counter and runs a req/ack handshake to instruction memory.
- Presents the fetched 32-bit instruction and its PC to decode. The instruction goes to the immediate generator and register-file read.
- Applies the next-PC choice: sequential (+4) or redirect from branch/jump resolution.
- Supports downstream stall and discards in-flight fetches made stale by a redirect.

Parameters:
- XLEN, 64, width of PC and addresses.
- RESET_PC, 64'h0000_0000_0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, held until imem_ack.
- imem_addr  out  XLEN  fetch address; stable while imem_req=1 and no ack.
- imem_ack  in  1  memory response valid this cycle (single-cycle pulse).
- imem_rdata  in  32  instruction word; valid with imem_ack.
- redirect_valid  in  1  branch/jump taken; target in redirect_pc.
- redirect_pc  in  XLEN  redirect target.
- stall  in  1  decode cannot accept this cycle.
- instr_valid  out  1  instr/instr_pc valid.
- instr  out  32  fetched instruction.
- instr_pc  out  XLEN  address of instr.
- misaligned_fault  out  1  sticky: redirect target not 4-byte aligned.

Behaviour:
- Reset values (async, immediate on reset):
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, misaligned_fault=0, discard=0.
- States: IDLE, FETCH, DRAIN, DELIVER, FAULT. imem_req=1 only in FETCH and DRAIN.
- IDLE:
  - Always goes to FETCH next cycle.
  - First imem_req is asserted 1 cycle after reset deasserts.
- FETCH:
  - imem_addr=pc.
  - On imem_ack (and no redirect): latch imem_rdata->instr, pc->instr_pc; go to DELIVER; instr_valid=1 from the next cycle.
  - Redirect with no ack: addr_hold<=pc, pc<=redirect_pc, go to DRAIN. imem_addr stays at the old address until ack.
  - Redirect together with ack: drop the response, pc<=redirect_pc, stay in FETCH. The new address is issued next cycle.
- DRAIN:
  - imem_addr=addr_hold, req held.
  - On ack: discard data, go to FETCH with the new pc.
  - A further redirect here overwrites pc only.
- DELIVER:
  - instr_valid=1. accept = instr_valid & ~stall.
  - On accept: instr_valid<=0, go to FETCH. pc<=redirect_valid ? redirect_pc : pc+4.
  - If stall=1: hold instr/instr_pc stable and ignore redirect_valid. A redirect is sampled only with accept.
- Misaligned redirect:
  - Any honoured redirect with redirect_pc[1:0]!=0 goes to FAULT: misaligned_fault<=1, no PC update.
  - In FAULT, imem_req=0 and instr_valid=0 until reset. A pending DRAIN ack is ignored.
- Arithmetic:
  - pc+4 is modulo 2^XLEN (64'hFFFF_FFFF_FFFF_FFFC -> 0).
  - pc[1:0] is always 00; compressed instructions are unsupported.
- Timing:
  - Zero-wait memory (ack in the request cycle) gives one instruction per 2 cycles.
  - ack -> instr_valid latency is exactly 1 cycle.
- imem_ack outside FETCH/DRAIN is ignored (protocol error, no state change).
- Reset mid-operation:
  - An outstanding request is abandoned and all outputs return to their reset values.
  - A late ack after reset, while in IDLE, is ignored.

Decomposition:
- Shared package core_pkg:
  - XLEN, NOP_INSTR (32'h0000_0013), RESET_PC default.
  - Opcode constants shared with decode and the immediate generator.
  - The fetch state enum (fetch_state_t).
- No sub-module needed; PC register, next-PC mux and FSM stay in one module.

Test Plan:
- Reset, zero-wait memory acking every request:
  - First imem_req with addr 0x0 one cycle after reset release.
  - instr_valid pulses with instr_pc 0x0, 0x4, 0x8, one instruction every 2 cycles.
- Stall held 3 cycles while DELIVER has instr 0x00A00093 at PC 0x8:
  - instr/instr_pc stable for all 3 cycles, no imem_req.
  - Next request is to 0xC after stall drops.
- Accept together with redirect_valid=1, redirect_pc=0x100:
  - Next imem_addr=0x100; the following instr_pc=0x100.
- Memory with 3-cycle ack latency, redirect to 0x200 in the first FETCH cycle for addr 0x10:
  - imem_addr stays 0x10 until ack; that data is never presented.
  - Next request is 0x200.
- Redirect_pc=0x102 on accept:
  - misaligned_fault=1 next cycle, imem_req stays 0, instr_valid stays 0 until reset.
- pc=0xFFFF_FFFF_FFFF_FFFC accepted without redirect:
  - Next imem_addr=0x0.
- Reset asserted mid-DRAIN:
  - Outputs return to reset values asynchronously.
  - A late ack after reset release is ignored.
